// File: rtl/unipolar_rz_multi_if.sv
// Upstream word stream for the multi-channel RZ transmitter: data plus target
// channel index, with a valid/ready handshake.
interface unipolar_rz_multi_if #(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNELS   = 4
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [DATA_WIDTH-1:0] in_data;
  logic [CW-1:0]         in_channel;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_channel, output in_valid, input in_ready);
  modport slave  (input in_data, input in_channel, input in_valid, output in_ready);
endinterface

// File: rtl/unipolar_rz_multi.sv
// Multi-channel unipolar return-to-zero serial transmitter. Each channel owns
// a small FIFO, a bit-timing FSM and one registered output line; channels
// only share the upstream word port. An end-of-frame reset gap is inserted
// whenever a channel runs dry and after reset.
module unipolar_rz_multi #(
  parameter int  DATA_WIDTH     = 24,
  parameter int  CHANNELS       = 4,
  parameter int  FIFO_DEPTH     = 4,
  parameter bit  MSB_FIRST      = 1'b1,
  parameter real CLOCK_RATE     = 50e6,
  parameter real ZERO_HIGH_TIME = 0.40e-6,
  parameter real ZERO_LOW_TIME  = 0.85e-6,
  parameter real ONE_HIGH_TIME  = 0.80e-6,
  parameter real ONE_LOW_TIME   = 0.45e-6,
  parameter real RESET_TIME     = 50e-6
) (
  input  logic                     clock,
  input  logic                     reset,
  unipolar_rz_multi_if.slave       bus,
  output wire  [CHANNELS-1:0]      line,
  output wire  [CHANNELS-1:0]      idle
);

  localparam int T0H  = int'(CLOCK_RATE * ZERO_HIGH_TIME);
  localparam int T0L  = int'(CLOCK_RATE * ZERO_LOW_TIME);
  localparam int T1H  = int'(CLOCK_RATE * ONE_HIGH_TIME);
  localparam int T1L  = int'(CLOCK_RATE * ONE_LOW_TIME);
  localparam int RSTC = int'(CLOCK_RATE * RESET_TIME);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max2(max2(max2(T0H, T0L), max2(T1H, T1L)), RSTC);
  localparam int CNTW = $clog2(MAXC + 1);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  if (T0H < 1 || T0L < 1 || T1H < 1 || T1L < 1 || RSTC < 1) begin : g_bad_timing
    $error("unipolar_rz_multi: every phase must last at least one clock cycle");
  end

  typedef enum logic [1:0] {IDLE, HIGH, LOW, RESET_GAP} state_t;

  logic [CHANNELS-1:0] full_vec;
  logic                in_ready_c;

  // A word for a missing channel is always taken and dropped; otherwise the
  // target FIFO's pre-edge full flag decides.
  always_comb begin
    in_ready_c = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (bus.in_channel == CW'(c)) in_ready_c = !full_vec[c];
    end
  end

  assign bus.in_ready = in_ready_c;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic                  head_bit;
    state_t                state;
    logic [CNTW-1:0]       cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  cur_bit;
    logic                  next_bit;
    logic [BW-1:0]         bits_left;
    logic                  line_q;

    assign empty        = (wr_ptr == rd_ptr);
    assign full_vec[ch] = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push         = bus.in_valid && in_ready_c && (bus.in_channel == CW'(ch));
    assign pop          = !empty && ((state == IDLE) ||
                          (state == LOW && cnt == '0 && bits_left == '0));
    assign head         = mem[rd_ptr[AW-1:0]];
    assign head_bit     = MSB_FIRST ? head[DATA_WIDTH-1] : head[0];
    assign shifted      = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
    assign cur_bit      = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];
    assign next_bit     = MSB_FIRST ? shifted[DATA_WIDTH-1] : shifted[0];

    assign line[ch] = line_q;
    assign idle[ch] = (state == IDLE) && empty;

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clock) begin
      if (push) mem[wr_ptr[AW-1:0]] <= bus.in_data;
    end

    // FIFO pointers advance on accepted pushes and on FSM pops.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end

    // Bit-timing FSM: high phase, low phase, chaining words back to back and
    // falling into the reset gap when the FIFO is dry.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state     <= RESET_GAP;
        cnt       <= CNTW'(RSTC - 1);
        shreg     <= '0;
        bits_left <= '0;
        line_q    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            line_q <= 1'b0;
            if (!empty) begin
              shreg     <= head;
              bits_left <= BW'(DATA_WIDTH - 1);
              line_q    <= 1'b1;
              cnt       <= head_bit ? CNTW'(T1H - 1) : CNTW'(T0H - 1);
              state     <= HIGH;
            end
          end
          HIGH: begin
            if (cnt == '0) begin
              line_q <= 1'b0;
              cnt    <= cur_bit ? CNTW'(T1L - 1) : CNTW'(T0L - 1);
              state  <= LOW;
            end else begin
              cnt <= cnt - CNTW'(1);
            end
          end
          LOW: begin
            if (cnt != '0) begin
              cnt <= cnt - CNTW'(1);
            end else if (bits_left != '0) begin
              shreg     <= shifted;
              bits_left <= bits_left - BW'(1);
              line_q    <= 1'b1;
              cnt       <= next_bit ? CNTW'(T1H - 1) : CNTW'(T0H - 1);
              state     <= HIGH;
            end else if (!empty) begin
              shreg     <= head;
              bits_left <= BW'(DATA_WIDTH - 1);
              line_q    <= 1'b1;
              cnt       <= head_bit ? CNTW'(T1H - 1) : CNTW'(T0H - 1);
              state     <= HIGH;
            end else begin
              cnt   <= CNTW'(RSTC - 1);
              state <= RESET_GAP;
            end
          end
          RESET_GAP: begin
            line_q <= 1'b0;
            if (cnt == '0) state <= IDLE;
            else           cnt   <= cnt - CNTW'(1);
          end
          default: begin
            line_q <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_unipolar_rz_multi.sv
// Self-checking bench for unipolar_rz_multi: directed scenarios plus a random
// traffic phase, all compared cycle by cycle against a waveform-level model.
module tb_unipolar_rz_multi;

  localparam int NCH   = 3;
  localparam int DEPTH = 4;
  localparam int RSTC  = 50;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] line;
  logic [NCH-1:0] idle;

  int vectors     = 0;
  int miscompares = 0;

  unipolar_rz_multi_if #(.DATA_WIDTH(8), .CHANNELS(NCH)) bus ();

  unipolar_rz_multi #(
    .DATA_WIDTH     (8),
    .CHANNELS       (NCH),
    .FIFO_DEPTH     (DEPTH),
    .MSB_FIRST      (1'b1),
    .CLOCK_RATE     (10e6),
    .ZERO_HIGH_TIME (0.4e-6),
    .ZERO_LOW_TIME  (0.8e-6),
    .ONE_HIGH_TIME  (0.8e-6),
    .ONE_LOW_TIME   (0.4e-6),
    .RESET_TIME     (5e-6)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .line  (line),
    .idle  (idle)
  );

  always #5 clock = ~clock;

  // Reference model: queued words, the exact list of line levels still to
  // emit for the current word, and the remaining reset-gap cycles.
  logic [7:0]     mq   [NCH][$];
  bit             wave [NCH][$];
  int             gap  [NCH];
  bit             ending [NCH];
  logic [NCH-1:0] exp_line;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      wave[c].delete();
      gap[c]      = RSTC;
      ending[c]   = 1'b0;
      exp_line[c] = 1'b0;
    end
  endtask

  task automatic load_word(input int c, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      int h = w[i] ? 8 : 4;
      int l = w[i] ? 4 : 8;
      repeat (h) wave[c].push_back(1'b1);
      repeat (l) wave[c].push_back(1'b0);
    end
  endtask

  function automatic logic [NCH-1:0] exp_idle();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++)
      r[c] = (wave[c].size() == 0) && !ending[c] && (gap[c] == 0) && (mq[c].size() == 0);
    return r;
  endfunction

  function automatic bit exp_ready(input int ch);
    if (ch >= NCH) return 1'b1;
    return mq[ch].size() < DEPTH;
  endfunction

  task automatic model_step(input bit acc, input int ch, input logic [7:0] d);
    if (reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      if (wave[c].size() > 0) begin
        exp_line[c] = wave[c].pop_front();
        if (wave[c].size() == 0) ending[c] = 1'b1;
      end else if (ending[c]) begin
        ending[c] = 1'b0;
        if (mq[c].size() > 0) begin
          load_word(c, mq[c].pop_front());
          exp_line[c] = wave[c].pop_front();
        end else begin
          gap[c]      = RSTC;
          exp_line[c] = 1'b0;
        end
      end else if (gap[c] > 0) begin
        gap[c]--;
        exp_line[c] = 1'b0;
      end else if (mq[c].size() > 0) begin
        load_word(c, mq[c].pop_front());
        exp_line[c] = wave[c].pop_front();
      end else begin
        exp_line[c] = 1'b0;
      end
    end
    if (acc && ch < NCH) mq[ch].push_back(d);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // One clock cycle: drive at the falling edge, check in_ready, advance the
  // model on the rising edge, then check line and idle at the next fall.
  task automatic applyStimulus(input bit v, input int ch, input logic [7:0] d);
    bit r;
    bus.in_valid   = v;
    bus.in_channel = 2'(ch);
    bus.in_data    = d;
    #1;
    r = exp_ready(ch);
    checkOutput("in_ready", {7'd0, bus.in_ready}, {7'd0, r});
    @(posedge clock);
    model_step(v && r, ch, d);
    @(negedge clock);
    checkOutput("line", {5'd0, line}, {5'd0, exp_line});
    checkOutput("idle", {5'd0, idle}, {5'd0, exp_idle()});
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(1'b0, 0, 8'h00);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_channel = '0;
    bus.in_data    = '0;
    model_reset();
    @(negedge clock);

    // Reset held, then released: 50-cycle gap before idle rises.
    idleCycles(3);
    reset = 1'b0;
    idleCycles(55);

    // Single word on channel 0, then its reset gap.
    applyStimulus(1'b1, 0, 8'hA5);
    idleCycles(160);

    // Two words back to back with no gap at the boundary.
    applyStimulus(1'b1, 0, 8'hFF);
    applyStimulus(1'b1, 0, 8'h00);
    idleCycles(260);

    // Flood channel 1 until backpressure; channel 0 stays ready meanwhile.
    repeat (10) applyStimulus(1'b1, 1, 8'($urandom));
    applyStimulus(1'b0, 0, 8'h00);
    repeat (120) applyStimulus(1'b1, 1, 8'($urandom));
    idleCycles(650);

    // Independent channels plus a write to a non-existent channel.
    applyStimulus(1'b1, 0, 8'h80);
    applyStimulus(1'b1, 2, 8'h01);
    applyStimulus(1'b1, 3, 8'hC3);
    idleCycles(170);

    // Random traffic across all channel indices.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0)
        applyStimulus(1'b1, int'($urandom_range(0, 3)), 8'($urandom));
      else
        applyStimulus(1'b0, int'($urandom_range(0, 3)), 8'($urandom));
    end
    idleCycles(700);

    // Reset mid-word on channel 2 with two words queued behind it.
    applyStimulus(1'b1, 2, 8'($urandom));
    applyStimulus(1'b1, 2, 8'($urandom));
    applyStimulus(1'b1, 2, 8'($urandom));
    idleCycles(28);
    reset = 1'b1;
    #1;
    model_reset();
    checkOutput("line_async_reset", {5'd0, line}, {5'd0, exp_line});
    @(negedge clock);
    idleCycles(2);
    reset = 1'b0;
    idleCycles(120);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
